sccb_cmd_arbiter: RTL

- Shares the single SCCB/I2C write engine (i2c_com: 32-bit i2c_data, start/tr_end handshake) among several command sources.
- Sources include the boot-time sensor register loader, a runtime exposure/gain writer and a debug/host register port.
- Performs round-robin arbitration, latches the winner's command, sequences the engine handshake and returns a per-requester completion pulse.
- Sits between the command sources and i2c_com, in the 20 kHz I2C clock domain.

---
 rtl/sccb_pkg.sv | 30 +++
 rtl/rr_pick.sv | 33 +++
 rtl/sccb_cmd_arbiter.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/sccb_pkg.sv
// Shared definitions for the SCCB command arbiter: FSM state encoding,
// command field layout and the camera device address.
package sccb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_START    = 2'd1,
        ST_WAIT_END = 2'd2,
        ST_RELEASE  = 2'd3
    } arb_state_e;

    // Command word layout: {dev_addr[7:0], reg_addr[15:0], reg_data[7:0]}
    localparam int unsigned CMD_DEV_LSB = 24;
    localparam int unsigned CMD_REG_LSB = 8;
    localparam int unsigned CMD_DAT_LSB = 0;

    localparam logic [7:0] OV9281_DEV_ADDR = 8'hc0;

    function automatic logic [31:0] cmd_pack(input logic [7:0]  dev,
                                             input logic [15:0] addr,
                                             input logic [7:0]  dat);
        logic [31:0] cmd;
        cmd = 32'h0000_0000;
        cmd[CMD_DEV_LSB +: 8]  = dev;
        cmd[CMD_REG_LSB +: 16] = addr;
        cmd[CMD_DAT_LSB +: 8]  = dat;
        return cmd;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: scans eligible from rr_ptr_i upward
// with explicit wrap at N and reports the first hit.
module rr_pick #(
    parameter int unsigned N  = 3,
    parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  eligible_i,
    input  logic [PW-1:0] rr_ptr_i,
    output logic [PW-1:0] win_o,
    output logic          valid_o
);

    logic [PW:0]   sum_s;
    logic [PW-1:0] idx_s;
    logic          hit_s;

    // Priority scan in rotated order; the first eligible index sticks.
    always_comb begin
        win_o   = {PW{1'b0}};
        valid_o = 1'b0;
        sum_s   = {(PW+1){1'b0}};
        idx_s   = {PW{1'b0}};
        hit_s   = 1'b0;
        for (int k = 0; k < N; k++) begin
            sum_s   = {1'b0, rr_ptr_i} + (PW+1)'(k);
            idx_s   = (sum_s >= (PW+1)'(N)) ? PW'(sum_s - (PW+1)'(N)) : PW'(sum_s);
            hit_s   = eligible_i[idx_s] & ~valid_o;
            win_o   = hit_s ? idx_s : win_o;
            valid_o = valid_o | hit_s;
        end
    end

endmodule

// File: rtl/sccb_cmd_arbiter.sv
// Round-robin arbiter sharing one SCCB write engine among NUM_REQ sources.
// Optional watchdog on the engine handshake: define SCCB_ARB_TIMEOUT_EN.
module sccb_cmd_arbiter
    import sccb_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 3,
    parameter int unsigned DW          = 32,
    parameter int unsigned TIMEOUT_CYC = 4000
) (
    input  logic                  clock_i2c,
    input  logic                  camera_rstn,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*DW-1:0] req_data,
    input  logic                  boot_lock,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [NUM_REQ-1:0]    done,
    output logic                  busy,
    output logic [DW-1:0]         i2c_data,
    output logic                  start,
    input  logic                  tr_end,
    output logic                  timeout_err
);

    localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [NUM_REQ-1:0] GNT_ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    arb_state_e           state_q, state_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic                 busy_q, busy_d;
    logic                 start_q, start_d;
    logic [DW-1:0]        data_q, data_d;
    logic [PW-1:0]        rr_ptr_q, rr_ptr_d;

    logic [NUM_REQ-1:0]   elig_s;
    logic [PW-1:0]        win_s;
    logic                 win_vld_s;
    logic [DW-1:0]        cmd_s [NUM_REQ];

`ifdef SCCB_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 terr_q, terr_d;
`endif

    // During the boot config phase only the sensor loader may compete.
    always_comb begin
        if (boot_lock) begin
            elig_s = {{(NUM_REQ-1){1'b0}}, req[0]};
        end else begin
            elig_s = req;
        end
    end

    // Unflatten the per-requester command words.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            cmd_s[i] = req_data[i*DW +: DW];
        end
    end

    rr_pick #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_rr_pick (
        .eligible_i (elig_s),
        .rr_ptr_i   (rr_ptr_q),
        .win_o      (win_s),
        .valid_o    (win_vld_s)
    );

    // Next-state and output decode for the grant/handshake sequence.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        done_d   = {NUM_REQ{1'b0}};
        start_d  = start_q;
        data_d   = data_q;
        rr_ptr_d = rr_ptr_q;
`ifdef SCCB_ARB_TIMEOUT_EN
        cnt_d    = cnt_q;
        terr_d   = terr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (win_vld_s) begin
                    gnt_d    = GNT_ONE << win_s;
                    data_d   = cmd_s[win_s];
                    rr_ptr_d = (win_s == PW'(NUM_REQ - 1)) ? {PW{1'b0}} : win_s + PW'(1);
                    state_d  = ST_START;
                end else begin
                    gnt_d    = {NUM_REQ{1'b0}};
                end
            end
            ST_START: begin
                start_d = 1'b1;
                state_d = ST_WAIT_END;
            end
            ST_WAIT_END: begin
                if (tr_end) begin
                    start_d = 1'b0;
                    done_d  = gnt_q;
                    state_d = ST_RELEASE;
                end else begin
                    start_d = 1'b1;
                end
            end
            ST_RELEASE: begin
                // Hold the grant until the engine has re-armed.
                if (!tr_end) begin
                    gnt_d   = {NUM_REQ{1'b0}};
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RELEASE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = {NUM_REQ{1'b0}};
                start_d = 1'b0;
            end
        endcase
`ifdef SCCB_ARB_TIMEOUT_EN
        // One shared budget covers both the transfer and the re-arm wait.
        if ((state_q == ST_WAIT_END) || (state_q == ST_RELEASE)) begin
            if (cnt_q == TMO_LAST) begin
                state_d = ST_IDLE;
                gnt_d   = {NUM_REQ{1'b0}};
                start_d = 1'b0;
                done_d  = {NUM_REQ{1'b0}};
                terr_d  = 1'b1;
                cnt_d   = {CW{1'b0}};
            end else begin
                cnt_d   = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = {CW{1'b0}};
        end
`endif
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset aborts any transfer in flight.
    always_ff @(posedge clock_i2c or negedge camera_rstn) begin
        if (!camera_rstn) begin
            state_q  <= ST_IDLE;
            gnt_q    <= {NUM_REQ{1'b0}};
            done_q   <= {NUM_REQ{1'b0}};
            busy_q   <= 1'b0;
            start_q  <= 1'b0;
            data_q   <= {DW{1'b0}};
            rr_ptr_q <= {PW{1'b0}};
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            start_q  <= start_d;
            data_q   <= data_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

`ifdef SCCB_ARB_TIMEOUT_EN
    // Watchdog counter and sticky error flag.
    always_ff @(posedge clock_i2c or negedge camera_rstn) begin
        if (!camera_rstn) begin
            cnt_q  <= {CW{1'b0}};
            terr_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            terr_q <= terr_d;
        end
    end

    assign timeout_err = terr_q;
`else
    assign timeout_err = 1'b0 & (TIMEOUT_CYC != 32'd0);
`endif

    assign gnt      = gnt_q;
    assign done     = done_q;
    assign busy     = busy_q;
    assign i2c_data = data_q;
    assign start    = start_q;

endmodule
